// File: rtl/multichannel_wavetable_pkg.sv
// wavetable_pkg: shared types and elaboration helpers for the multichannel
// wavetable oscillator.
//   wave_mode_t  - per-channel waveform selector carried in the config word
//   wt_state_t   - frame sequencer states
//   phase_k()    - 64-bit frequency-to-increment scale factor
//   ch_bits(), ch_lsb(), mode_lsb() - config word field geometry
package wavetable_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WT   = 2'd2,
    ST_EMIT = 2'd3
  } wt_state_t;

  // Frequency words are Q15.9 Hz, so (freq * K) >> 32 yields the phase step
  // per output frame when K = round(2^(PHASE_WIDTH+23) / SAMPLE_RATE_HZ).
  function automatic logic [63:0] phase_k(input int unsigned phase_width,
                                          input int unsigned sample_rate);
    logic [63:0] num;
    num = 64'd1 << (phase_width + 23);
    return (num + 64'(sample_rate / 2)) / 64'(sample_rate);
  endfunction

  function automatic int unsigned ch_bits(input int unsigned num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

  // Config word layout: {mode[1:0], channel[CH_BITS-1:0], freq[FREQ_WIDTH-1:0]}
  localparam int unsigned FREQ_LSB = 0;

  function automatic int unsigned ch_lsb(input int unsigned freq_width);
    return freq_width;
  endfunction

  function automatic int unsigned mode_lsb(input int unsigned freq_width,
                                           input int unsigned chb);
    return freq_width + chb;
  endfunction

endpackage

// File: rtl/multichannel_wavetable_if.sv
// Axis_If: minimal AXI-Stream style channel (valid/ready/data/last).
//   master: drives valid, data, last; samples ready
//   slave : samples valid, data, last; drives ready
interface Axis_If #(
  parameter int unsigned WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic             last;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/multichannel_wavetable_sine_quarter_rom.sv
// sine_quarter_rom: quarter-wave sine magnitude table with a registered read.
//   clk  - read clock
//   addr - table index, 0..2^LUT_ADDR_BITS-1
//   data - round(M * sin((addr+0.5)*pi/2^(LUT_ADDR_BITS+1))), valid 1 cycle later
// The half-LSB offset makes the table symmetric, so mirroring the index with
// ~addr reproduces the second quarter exactly.
module sine_quarter_rom #(
  parameter int unsigned LUT_ADDR_BITS = 10,
  parameter int unsigned SAMPLE_WIDTH  = 24
) (
  input  logic                     clk,
  input  logic [LUT_ADDR_BITS-1:0] addr,
  output logic [SAMPLE_WIDTH-2:0]  data
);
  localparam int unsigned DEPTH = 1 << LUT_ADDR_BITS;
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = (2.0 ** (SAMPLE_WIDTH - 1)) - 1.0;

  logic [SAMPLE_WIDTH-2:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam real ANG = (real'(i) + 0.5) * PI / real'(2 * DEPTH);
    localparam logic [SAMPLE_WIDTH-2:0] VAL =
      (SAMPLE_WIDTH-1)'($rtoi(AMP * $sin(ANG) + 0.5));
    assign rom[i] = VAL;
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end
endmodule

// File: rtl/multichannel_wavetable.sv
// multichannel_wavetable: NUM_CHANNELS independent oscillators (sine, square,
// saw, triangle) time-multiplexed onto one sample stream at SAMPLE_RATE_HZ.
//   clk      - system clock (CLK_RATE_HZ)
//   reset_n  - asynchronous active-low reset
//   freq     - config slave, data = {mode[1:0], channel, freq Q15.9 Hz}
//   data_out - sample master, signed SAMPLE_WIDTH; last on channel NUM_CHANNELS-1
//   overrun  - sticky: a frame tick arrived while the previous frame was pending
module multichannel_wavetable
  import wavetable_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned SAMPLE_WIDTH   = 24,
  parameter int unsigned FREQ_WIDTH     = 24,
  parameter int unsigned PHASE_WIDTH    = 32,
  parameter int unsigned LUT_ADDR_BITS  = 10,
  parameter int unsigned CLK_RATE_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_RATE_HZ = 48_000
) (
  input  logic  clk,
  input  logic  reset_n,
  Axis_If.slave  freq,
  Axis_If.master data_out,
  output logic  overrun
);
  localparam int unsigned CH_BITS  = ch_bits(NUM_CHANNELS);
  localparam int unsigned CH_LSB   = ch_lsb(FREQ_WIDTH);
  localparam int unsigned MODE_LSB = mode_lsb(FREQ_WIDTH, CH_BITS);
  localparam logic [63:0] K        = phase_k(PHASE_WIDTH, SAMPLE_RATE_HZ);
  localparam int unsigned DIV      = CLK_RATE_HZ / SAMPLE_RATE_HZ;
  localparam int unsigned CNT_BITS = $clog2(DIV);
  localparam int unsigned P        = PHASE_WIDTH;
  localparam int unsigned W        = SAMPLE_WIDTH;
  localparam int unsigned A        = LUT_ADDR_BITS;
  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CHANNELS - 1);
  localparam logic [W-1:0] POS_M  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W:0]   HALF_X = {2'b01, {(W-1){1'b0}}};
  localparam logic [W:0]   M_X    = {2'b00, {(W-1){1'b1}}};

  // ---------------- config path ----------------
  logic                  ready_q;
  logic [FREQ_WIDTH-1:0] wr_freq;
  logic [CH_BITS-1:0]    wr_ch;
  logic [31:0]           wr_ch_ext;
  wave_mode_t            wr_mode;
  logic [63:0]           wr_prod;
  logic [P-1:0]          wr_inc;
  logic [P-1:0]          inc_r  [NUM_CHANNELS];
  wave_mode_t            mode_r [NUM_CHANNELS];

  assign wr_freq   = freq.data[FREQ_LSB +: FREQ_WIDTH];
  assign wr_ch     = freq.data[CH_LSB +: CH_BITS];
  assign wr_ch_ext = 32'(wr_ch);
  assign wr_mode   = wave_mode_t'(freq.data[MODE_LSB +: 2]);
  assign wr_prod   = 64'(wr_freq) * K;
  assign wr_inc    = wr_prod[32 +: P];
  assign freq.ready = ready_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      inc_r   <= '{default: '0};
      mode_r  <= '{default: WAVE_SINE};
    end else begin
      ready_q <= 1'b1;
      // Out-of-range channel indices are accepted but discarded.
      if (freq.valid && ready_q && (wr_ch_ext < NUM_CHANNELS)) begin
        inc_r[wr_ch]  <= wr_inc;
        mode_r[wr_ch] <= wr_mode;
      end
    end
  end

  // ---------------- frame tick ----------------
  logic [CNT_BITS-1:0] tick_cnt;
  logic                tick;

  assign tick = (tick_cnt == CNT_BITS'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  // ---------------- frame sequencer ----------------
  wt_state_t          state;
  logic [CH_BITS-1:0] ch;
  logic [P-1:0]       phase_r [NUM_CHANNELS];
  logic [P-1:0]       cur_phase;
  logic [P-1:0]       p_q;
  wave_mode_t         mode_q;
  logic [A-1:0]       raw_addr;
  logic [A-1:0]       rom_addr;
  logic [W-2:0]       rom_q;
  logic [W-1:0]       sample;
  logic [W:0]         tri_t;
  logic [W:0]         tri_x;
  logic               out_valid;
  logic               out_last;
  logic [W-1:0]       out_data;

  assign cur_phase = phase_r[ch];
  assign raw_addr  = cur_phase[P-3 -: A];
  // Odd quadrants run the quarter table backwards.
  assign rom_addr  = cur_phase[P-2] ? ~raw_addr : raw_addr;

  sine_quarter_rom #(
    .LUT_ADDR_BITS(LUT_ADDR_BITS),
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_rom (
    .clk (clk),
    .addr(rom_addr),
    .data(rom_q)
  );

  always_comb begin
    sample = '0;
    tri_t  = {1'b0, p_q[P-2 -: W]};
    tri_x  = p_q[P-1] ? (M_X - tri_t) : (tri_t - HALF_X);
    case (mode_q)
      WAVE_SINE:   sample = p_q[P-1] ? -{1'b0, rom_q} : {1'b0, rom_q};
      WAVE_SQUARE: sample = p_q[P-1] ? -POS_M : POS_M;
      WAVE_SAW:    sample = {~p_q[P-1], p_q[P-2 -: W-1]};
      WAVE_TRI:    sample = tri_x[W-1:0];
      default:     sample = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ch        <= '0;
      p_q       <= '0;
      mode_q    <= WAVE_SINE;
      phase_r   <= '{default: '0};
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      // Ticks outside IDLE are dropped; the pending frame still completes.
      if (tick && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (tick) begin
            ch    <= '0;
            state <= ST_RD;
          end
        end
        ST_RD: begin
          p_q         <= cur_phase;
          mode_q      <= mode_r[ch];
          phase_r[ch] <= cur_phase + inc_r[ch];
          state       <= ST_WT;
        end
        ST_WT: begin
          out_data  <= sample;
          out_last  <= (ch == LAST_CH);
          out_valid <= 1'b1;
          state     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (data_out.ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= ST_IDLE;
            end else begin
              ch    <= ch + 1'b1;
              state <= ST_RD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_out.valid = out_valid;
  assign data_out.last  = out_last;
  assign data_out.data  = out_data;

  logic unused_bits;
  assign unused_bits = ^{freq.last, wr_prod[31:0], tri_x[W], p_q[P-W-2:0]};
endmodule

// File: tb/tb_multichannel_wavetable.sv
module tb_multichannel_wavetable;
  localparam int unsigned DIV = 2083;
  localparam int unsigned NF  = 28;

  typedef struct {
    logic [23:0] data;
    logic        last;
    int unsigned frame;
    int unsigned ch;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic overrun;

  Axis_If #(.WIDTH(28)) cfg_if ();
  Axis_If #(.WIDTH(24)) out_if ();

  multichannel_wavetable #(
    .NUM_CHANNELS  (4),
    .SAMPLE_WIDTH  (24),
    .FREQ_WIDTH    (24),
    .PHASE_WIDTH   (32),
    .LUT_ADDR_BITS (10),
    .CLK_RATE_HZ   (100_000_000),
    .SAMPLE_RATE_HZ(48_000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .freq    (cfg_if),
    .data_out(out_if),
    .overrun (overrun)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned beats    = 0;
  int unsigned cyc      = 0;
  int unsigned t_start [NF];
  beat_t       exp_q [$];
  logic        stalled = 1'b0;
  logic [23:0] held = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Hand-derived expectations:
  //  ch0 square, inc 89478485: phase f*inc stays below 2^31 up to f = 24.
  //  ch1 sine at 24'h5DC001, inc 2^30+174: quadrants cycle 0,1,2,3 with a = 0,
  //      so ROM[0] = 6434, ROM[1023] = 8388605 with alternating sign.
  //      (The exact 12 kHz word truncates to 2^30-1 and drifts a quadrant edge.)
  //  ch2 saw / ch3 triangle at 0 Hz: phase stays 0, both give -2^23.
  function automatic beat_t exp_beat(input int unsigned f, input int unsigned c);
    beat_t b;
    b.frame = f;
    b.ch    = c;
    b.last  = (c == 3);
    case (c)
      0: b.data = (f <= 24) ? 24'h7FFFFF : 24'h800001;
      1: case (f % 4)
           0:       b.data = 24'd6434;
           1:       b.data = 24'd8388605;
           2:       b.data = 24'(-6434);
           default: b.data = 24'(-8388605);
         endcase
      default: b.data = 24'h800000;
    endcase
    return b;
  endfunction

  // Monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (reset_n && out_if.valid && out_if.ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_beat: got data 0x%0h last %0b, no beat expected", out_if.data, out_if.last);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("f%0d_ch%0d_data", e.frame, e.ch), 64'(out_if.data), 64'(e.data));
        check($sformatf("f%0d_ch%0d_last", e.frame, e.ch), 64'(out_if.last), 64'(e.last));
        if (e.ch == 0) t_start[e.frame] = cyc;
      end
      beats++;
      stalled = 1'b0;
    end else if (reset_n && out_if.valid) begin
      if (stalled) check("stall_hold_data", 64'(out_if.data), 64'(held));
      held    = out_if.data;
      stalled = 1'b1;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic cfg_write(input logic [1:0] mode, input logic [1:0] ch, input logic [23:0] f);
    int unsigned g;
    g = 0;
    cfg_if.data  = {mode, ch, f};
    cfg_if.valid = 1'b1;
    while (!cfg_if.ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("cfg_ready_seen", 64'(cfg_if.ready), 64'd1);
    @(posedge clk); #1;
    cfg_if.valid = 1'b0;
  endtask

  task automatic wait_beats(input int unsigned n, input int unsigned budget, input string what);
    int unsigned g;
    g = 0;
    while (beats < n && g < budget) begin
      @(posedge clk);
      g++;
    end
    check(what, 64'(beats), 64'(n));
  endtask

  initial begin : stim
    int unsigned g;
    int unsigned vh;
    cfg_if.valid = 1'b0;
    cfg_if.last  = 1'b0;
    cfg_if.data  = '0;
    out_if.ready = 1'b1;
    for (int i = 0; i < NF; i++) t_start[i] = 0;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_valid",   64'(out_if.valid), 64'd0);
    check("rst_last",    64'(out_if.last),  64'd0);
    check("rst_data",    64'(out_if.data),  64'd0);
    check("rst_ready",   64'(cfg_if.ready), 64'd0);
    check("rst_overrun", 64'(overrun),      64'd0);
    reset_n = 1'b1;

    for (int f = 0; f < NF; f++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back(exp_beat(f, c));

    cfg_write(2'd1, 2'd0, 24'h07D000);
    cfg_write(2'd0, 2'd1, 24'h5DC001);
    cfg_write(2'd2, 2'd2, 24'h000000);
    cfg_write(2'd3, 2'd3, 24'h000000);

    // Free-running frames 0..19
    wait_beats(80, 21 * DIV, "beats_frames_0_19");
    check("overrun_before_stall", 64'(overrun), 64'd0);

    // Backpressure across several ticks
    @(posedge clk); #1;
    out_if.ready = 1'b0;
    repeat (3 * DIV) @(posedge clk);
    #1;
    check("overrun_after_stall", 64'(overrun), 64'd1);
    check("no_beats_while_stalled", 64'(beats), 64'd80);
    out_if.ready = 1'b1;

    wait_beats(4 * NF, 12 * DIV, "beats_all_frames");
    check("overrun_sticky", 64'(overrun), 64'd1);

    for (int f = 1; f < NF; f++) begin
      if (f <= 19 || f >= 22)
        check($sformatf("frame_interval_%0d", f), 64'(t_start[f] - t_start[f-1]), 64'(DIV));
    end
    check("resume_on_tick_grid", 64'((t_start[21] - t_start[19]) % DIV), 64'd0);

    // Reset asserted while a beat is being presented
    @(posedge clk); #1;
    out_if.ready = 1'b0;
    g = 0;
    while (!out_if.valid && g < 2 * DIV) begin
      @(posedge clk); #1;
      g++;
    end
    check("emit_reached", 64'(out_if.valid), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("midframe_rst_valid",   64'(out_if.valid), 64'd0);
    check("midframe_rst_last",    64'(out_if.last),  64'd0);
    check("midframe_rst_overrun", 64'(overrun),      64'd0);
    check("midframe_rst_ready",   64'(cfg_if.ready), 64'd0);
    out_if.ready = 1'b1;
    vh = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_if.valid) vh++;
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (out_if.valid) vh++;
    end
    check("no_valid_after_abort", 64'(vh), 64'd0);
    check("total_beats", 64'(beats), 64'(4 * NF));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
